load_store_unit: RTL and testbench

//  Executes the memory operations selected by decode's load_type/store_type codes.

---
 rtl/load_store_unit_if.sv | 44 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - execute, data-memory and writeback signal bundle for the LSU.
interface load_store_unit_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      load_type;
  logic [1:0]      store_type;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic [RD_W-1:0] rd;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            resp_valid;
  logic            resp_ready;
  logic            resp_we;
  logic [RD_W-1:0] resp_rd;
  logic [XLEN-1:0] resp_data;
  logic            resp_misalign;
  logic            resp_illegal;

  modport slave (
    input  in_valid, load_type, store_type, addr, store_data, rd,
    input  mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output resp_valid, resp_we, resp_rd, resp_data, resp_misalign, resp_illegal
  );

  modport master (
    output in_valid, load_type, store_type, addr, store_data, rd,
    output mem_gnt, mem_rvalid, mem_rdata, resp_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  resp_valid, resp_we, resp_rd, resp_data, resp_misalign, resp_illegal
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding blocking load/store unit with strobes and load extension.
module load_store_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input logic               i_clk,
  input logic               i_rst_n,
  load_store_unit_if.slave  io_bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      r_state;
  logic [2:0]      r_ld;
  logic [1:0]      r_lane;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [3:0]      r_mem_wstrb;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_resp_we;
  logic [RD_W-1:0] r_resp_rd;
  logic [XLEN-1:0] r_resp_data;
  logic            r_resp_misalign;
  logic            r_resp_illegal;

  logic [2:0]      w_ld;
  logic [1:0]      w_st;
  logic            w_illegal;
  logic            w_half;
  logic            w_word;
  logic            w_misalign;
  logic [3:0]      w_strb;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_hword;
  logic [XLEN-1:0] w_load;

  assign w_ld = io_bus.load_type;
  assign w_st = io_bus.store_type;

  // Illegal encodings take priority, so misalignment is only flagged on a legal op.
  assign w_illegal  = ((w_ld == 3'd0) && (w_st == 2'd0)) ||
                      ((w_ld != 3'd0) && (w_st != 2'd0)) ||
                      (w_ld > 3'd5);
  assign w_half     = (w_ld == 3'd3) || (w_ld == 3'd4) || (w_st == 2'd2);
  assign w_word     = (w_ld == 3'd5) || (w_st == 2'd3);
  assign w_misalign = !w_illegal && ((w_half && io_bus.addr[0]) ||
                                     (w_word && (io_bus.addr[1:0] != 2'b00)));

  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = io_bus.store_data;
    case (w_st)
      2'd1: begin
        w_strb  = 4'b0001 << io_bus.addr[1:0];
        w_wdata = {4{io_bus.store_data[7:0]}};
      end
      2'd2: begin
        w_strb  = 4'b0011 << io_bus.addr[1:0];
        w_wdata = {2{io_bus.store_data[15:0]}};
      end
      2'd3:    w_strb = 4'b1111;
      default: w_strb = 4'b0000;
    endcase
  end

  assign w_byte  = io_bus.mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_hword = io_bus.mem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = io_bus.mem_rdata;
    case (r_ld)
      3'd1:    w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'd2:    w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'd3:    w_load = {{(XLEN-16){w_hword[15]}}, w_hword};
      3'd4:    w_load = {{(XLEN-16){1'b0}}, w_hword};
      default: w_load = io_bus.mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_ld            <= 3'd0;
      r_lane          <= 2'd0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wstrb     <= 4'b0000;
      r_mem_wdata     <= '0;
      r_resp_we       <= 1'b0;
      r_resp_rd       <= '0;
      r_resp_data     <= '0;
      r_resp_misalign <= 1'b0;
      r_resp_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.in_valid) begin
            r_ld            <= w_ld;
            r_lane          <= io_bus.addr[1:0];
            r_resp_rd       <= io_bus.rd;
            r_resp_misalign <= w_misalign;
            r_resp_illegal  <= w_illegal;
            r_resp_we       <= 1'b0;
            r_resp_data     <= '0;
            if (w_illegal || w_misalign) begin
              r_state <= S_RESP;
            end else begin
              r_state     <= S_REQ;
              r_mem_addr  <= {io_bus.addr[XLEN-1:2], 2'b00};
              r_mem_we    <= (w_st != 2'd0);
              r_mem_wstrb <= w_strb;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (io_bus.mem_gnt) r_state <= r_mem_we ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (io_bus.mem_rvalid) begin
            r_resp_data <= w_load;
            r_resp_we   <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        default: begin
          if (io_bus.resp_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready      = (r_state == S_IDLE);
  assign io_bus.mem_req       = (r_state == S_REQ);
  assign io_bus.mem_we        = r_mem_we;
  assign io_bus.mem_addr      = r_mem_addr;
  assign io_bus.mem_wstrb     = r_mem_wstrb;
  assign io_bus.mem_wdata     = r_mem_wdata;
  assign io_bus.resp_valid    = (r_state == S_RESP);
  assign io_bus.resp_we       = r_resp_we;
  assign io_bus.resp_rd       = r_resp_rd;
  assign io_bus.resp_data     = r_resp_data;
  assign io_bus.resp_misalign = r_resp_misalign;
  assign io_bus.resp_illegal  = r_resp_illegal;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a reactive memory/writeback model.
module tb_load_store_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
  } mem_exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        ill;
    int          rdy_dly;
    int          lat;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  int        acc_q[$];

  load_store_unit_if #(.XLEN(32), .RD_W(5)) b ();

  load_store_unit #(.XLEN(32), .RD_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!b.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b.in_ready) chk("in_ready_timeout", {31'd0, b.in_ready}, 32'd1);
    b.in_valid   = 1'b1;
    b.load_type  = ld;
    b.store_type = st;
    b.addr       = a;
    b.store_data = sd;
    b.rd         = rd;
    if (track) acc_q.push_back(cyc);
    @(posedge clk);
    #1 b.in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] ld, input logic [31:0] a, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic [31:0] exp_data,
                         input int gd, input int rvd, input int rdd, input int lat);
    mem_q.push_back('{addr: {a[31:2], 2'b00}, we: 1'b0, wstrb: 4'b0000, wdata: 32'd0,
                      gnt_dly: gd, rv_dly: rvd, rdata: rdata});
    resp_q.push_back('{we: 1'b1, rd: rd, data: exp_data, mis: 1'b0, ill: 1'b0,
                       rdy_dly: rdd, lat: lat});
    issue(ld, 2'd0, a, 32'h5555_AAAA, rd, 1'b1);
  endtask

  task automatic do_store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input logic [3:0] strb, input logic [31:0] wd,
                          input int gd, input int rdd, input int lat);
    mem_q.push_back('{addr: {a[31:2], 2'b00}, we: 1'b1, wstrb: strb, wdata: wd,
                      gnt_dly: gd, rv_dly: 0, rdata: 32'd0});
    resp_q.push_back('{we: 1'b0, rd: rd, data: 32'd0, mis: 1'b0, ill: 1'b0,
                       rdy_dly: rdd, lat: lat});
    issue(3'd0, st, a, sd, rd, 1'b1);
  endtask

  task automatic do_err(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                        input logic [4:0] rd, input logic mis, input logic ill);
    resp_q.push_back('{we: 1'b0, rd: rd, data: 32'd0, mis: mis, ill: ill,
                       rdy_dly: 0, lat: -1});
    issue(ld, st, a, 32'hFFFF_FFFF, rd, 1'b1);
  endtask

  // Memory side: grants after gnt_dly cycles of mem_req, returns rvalid rv_dly cycles after gnt+1.
  initial begin : mem_model
    mem_exp_t    e;
    int          wc;
    int          rc;
    bit          busy;
    bit          pend;
    logic [31:0] rdat;
    busy = 1'b0;
    pend = 1'b0;
    wc   = 0;
    rc   = 0;
    rdat = 32'd0;
    forever begin
      @(negedge clk);
      b.mem_gnt    = 1'b0;
      b.mem_rvalid = 1'b0;
      b.mem_rdata  = 32'hBAD0_BAD0;
      if (pend) begin
        if (rc == 0) begin
          b.mem_rvalid = 1'b1;
          b.mem_rdata  = rdat;
          pend         = 1'b0;
        end else begin
          rc--;
        end
      end
      if (b.mem_req) begin
        if (mem_q.size() == 0) begin
          chk("mem_req_unexpected", {31'd0, b.mem_req}, 32'd0);
        end else begin
          if (!busy) begin
            busy = 1'b1;
            wc   = mem_q[0].gnt_dly;
          end
          e = mem_q[0];
          chk("mem_addr", b.mem_addr, e.addr);
          chk("mem_we", {31'd0, b.mem_we}, {31'd0, e.we});
          chk("mem_wstrb", {28'd0, b.mem_wstrb}, {28'd0, e.wstrb});
          if (e.we) chk("mem_wdata", b.mem_wdata, e.wdata);
          chk("in_ready_during_req", {31'd0, b.in_ready}, 32'd0);
          if (wc == 0) begin
            b.mem_gnt = 1'b1;
            void'(mem_q.pop_front());
            busy = 1'b0;
            if (!e.we) begin
              pend = 1'b1;
              rc   = e.rv_dly;
              rdat = e.rdata;
            end
          end else begin
            wc--;
          end
        end
      end
    end
  end

  // Writeback side: compares each completion (every cycle it is held) and pops on consume.
  initial begin : resp_mon
    resp_exp_t e;
    bit        rbusy;
    int        rc;
    int        acc;
    rbusy = 1'b0;
    rc    = 0;
    acc   = 0;
    forever begin
      @(negedge clk);
      if (b.resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_valid_unexpected", {31'd0, b.resp_valid}, 32'd0);
          b.resp_ready = 1'b1;
        end else begin
          e = resp_q[0];
          if (!rbusy) begin
            rbusy = 1'b1;
            rc    = e.rdy_dly;
            acc   = (acc_q.size() != 0) ? acc_q.pop_front() : 0;
            if (e.lat >= 0) chk("latency", cyc - acc, e.lat);
          end
          chk("resp_we", {31'd0, b.resp_we}, {31'd0, e.we});
          chk("resp_rd", {27'd0, b.resp_rd}, {27'd0, e.rd});
          chk("resp_data", b.resp_data, e.data);
          chk("resp_misalign", {31'd0, b.resp_misalign}, {31'd0, e.mis});
          chk("resp_illegal", {31'd0, b.resp_illegal}, {31'd0, e.ill});
          chk("in_ready_during_resp", {31'd0, b.in_ready}, 32'd0);
          if (rc == 0) begin
            b.resp_ready = 1'b1;
            void'(resp_q.pop_front());
            rbusy = 1'b0;
          end else begin
            b.resp_ready = 1'b0;
            rc--;
          end
        end
      end else begin
        b.resp_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    b.in_valid   = 1'b0;
    b.load_type  = 3'd0;
    b.store_type = 2'd0;
    b.addr       = 32'd0;
    b.store_data = 32'd0;
    b.rd         = 5'd0;
    b.mem_gnt    = 1'b0;
    b.mem_rvalid = 1'b0;
    b.mem_rdata  = 32'd0;
    b.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, b.in_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, b.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, b.mem_we}, 32'd0);
    chk("rst_mem_addr", b.mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'd0, b.mem_wstrb}, 32'd0);
    chk("rst_mem_wdata", b.mem_wdata, 32'd0);
    chk("rst_resp_valid", {31'd0, b.resp_valid}, 32'd0);
    chk("rst_resp_we", {31'd0, b.resp_we}, 32'd0);
    chk("rst_resp_data", b.resp_data, 32'd0);
    chk("rst_resp_flags", {30'd0, b.resp_misalign, b.resp_illegal}, 32'd0);
    rst_n = 1'b1;

    do_load(3'd5, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 3);
    do_load(3'd1, 32'h0000_0103, 32'h8011_2233, 5'd7, 32'hFFFF_FF80, 0, 0, 0, 3);
    do_load(3'd2, 32'h0000_0103, 32'h8011_2233, 5'd8, 32'h0000_0080, 0, 0, 0, 3);
    do_store(2'd2, 32'h0000_0202, 32'h1234_ABCD, 5'd9, 4'b1100, 32'hABCD_ABCD, 0, 0, 2);
    do_err(3'd5, 2'd0, 32'h0000_0101, 5'd3, 1'b1, 1'b0);
    do_err(3'd1, 2'd1, 32'h0000_0100, 5'd4, 1'b0, 1'b1);
    do_store(2'd3, 32'h0000_0300, 32'hCAFE_F00D, 5'd10, 4'b1111, 32'hCAFE_F00D, 5, 3, -1);
    do_load(3'd3, 32'h0000_0102, 32'h8001_7FFF, 5'd11, 32'hFFFF_8001, 0, 0, 0, 3);
    do_load(3'd4, 32'h0000_0100, 32'h8001_F00F, 5'd12, 32'h0000_F00F, 0, 0, 0, 3);
    do_load(3'd1, 32'h0000_0101, 32'h0000_7F00, 5'd13, 32'h0000_007F, 0, 0, 0, 3);
    do_store(2'd1, 32'h0000_0101, 32'h0000_00A5, 5'd14, 4'b0010, 32'hA5A5_A5A5, 0, 0, 2);
    do_store(2'd1, 32'h0000_0103, 32'h1111_2233, 5'd15, 4'b1000, 32'h3333_3333, 1, 1, -1);
    do_load(3'd5, 32'h0000_0104, 32'h1234_5678, 5'd16, 32'h1234_5678, 2, 2, 2, -1);
    do_err(3'd7, 2'd0, 32'h0000_0100, 5'd17, 1'b0, 1'b1);
    do_err(3'd0, 2'd0, 32'h0000_0100, 5'd18, 1'b0, 1'b1);
    do_err(3'd3, 2'd0, 32'h0000_0101, 5'd19, 1'b1, 1'b0);
    do_err(3'd6, 2'd0, 32'h0000_0101, 5'd20, 1'b0, 1'b1);
    do_err(3'd0, 2'd3, 32'h0000_0302, 5'd21, 1'b1, 1'b0);

    // Abort a load in WAIT; its late rvalid must not produce a completion.
    mem_q.push_back('{addr: 32'h0000_0400, we: 1'b0, wstrb: 4'b0000, wdata: 32'd0,
                      gnt_dly: 0, rv_dly: 4, rdata: 32'h7777_7777});
    issue(3'd5, 2'd0, 32'h0000_0400, 32'd0, 5'd22, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, b.in_ready}, 32'd1);
    chk("abort_mem_req", {31'd0, b.mem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_idle_in_ready", {31'd0, b.in_ready}, 32'd1);
      chk("abort_no_resp", {31'd0, b.resp_valid}, 32'd0);
    end

    do_load(3'd5, 32'h0000_0500, 32'h0BAD_F00D, 5'd23, 32'h0BAD_F00D, 0, 0, 0, 3);

    n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_resp_q", resp_q.size(), 32'd0);
    chk("drain_mem_q", mem_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
